// File: rtl/seq_det_sched_pkg.sv
// Shared types and next-state logic for the two-consecutive-ones detector engine.
package seq_det_pkg;

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  function automatic state_t seq_next(state_t s, logic b);
    if (!b) return S0;
    case (s)
      S0:      return S1;
      S1:      return S2;
      default: return S3;
    endcase
  endfunction

  // A run of ones reports once, on the step that first reaches S2.
  function automatic logic is_hit(state_t cur, state_t nxt);
    return (nxt == S2) && (cur != S2);
  endfunction

endpackage

// File: rtl/seq_det_sched_if.sv
// Channel-side bit handshakes and the tagged detection output stream.
interface seq_det_sched_if #(
  parameter int NCH = 4
);
  localparam int CHW = $clog2(NCH);

  logic [NCH-1:0] ch_valid;
  logic [NCH-1:0] ch_bit;
  logic [NCH-1:0] ch_ready;
  logic [NCH-1:0] ch_clear;
  logic           det_valid;
  logic [CHW-1:0] det_ch;
  logic           det_ready;

  modport master (
    output ch_valid, ch_bit, ch_clear, det_ready,
    input  ch_ready, det_valid, det_ch
  );

  modport slave (
    input  ch_valid, ch_bit, ch_clear, det_ready,
    output ch_ready, det_valid, det_ch
  );
endinterface

// File: rtl/seq_det_sched_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after i_ptr, modulo N.
module rr_arb #(
  parameter int N   = 4,
  parameter int CHW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [CHW-1:0] i_ptr,
  input  logic           i_en,
  output logic [N-1:0]   o_gnt,
  output logic [CHW-1:0] o_gnt_idx,
  output logic           o_gnt_any
);

  logic [CHW:0]   w_sum;
  logic [CHW-1:0] w_idx;

  // The extra sum bit keeps the wrap correct when N is not a power of two.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_any = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (CHW+1)'(k);
      if (w_sum >= (CHW+1)'(N)) w_sum = w_sum - (CHW+1)'(N);
      w_idx = w_sum[CHW-1:0];
      if (i_en && !o_gnt_any && i_req[w_idx]) begin
        o_gnt_any    = 1'b1;
        o_gnt_idx    = w_idx;
        o_gnt[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Shares one sequence-detector engine across NCH serial channels with per-channel context.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int NCH = 4
) (
  input logic            clk,
  input logic            rst_n,
  seq_det_sched_if.slave bus
);

  localparam int CHW = $clog2(NCH);

  state_t         r_ctx [NCH];
  logic [CHW-1:0] r_rrPtr;
  logic           r_detValid;
  logic [CHW-1:0] r_detCh;

  logic           w_engOk;
  logic [NCH-1:0] w_req;
  logic [NCH-1:0] w_gnt;
  logic [CHW-1:0] w_gidx;
  logic           w_gany;
  state_t         w_cur;
  state_t         w_nxt;
  logic           w_hit;

  // A stalled event blocks every channel so the output register can hold.
  assign w_engOk = !r_detValid || bus.det_ready;
  assign w_req   = bus.ch_valid & ~bus.ch_clear;

  rr_arb #(.N(NCH), .CHW(CHW)) u_arb (
    .i_req     (w_req),
    .i_ptr     (r_rrPtr),
    .i_en      (w_engOk),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gidx),
    .o_gnt_any (w_gany)
  );

  assign bus.ch_ready  = rst_n ? w_gnt : '0;
  assign bus.det_valid = r_detValid;
  assign bus.det_ch    = r_detCh;

  always_comb begin
    w_cur = S0;
    w_nxt = S0;
    w_hit = 1'b0;
    if (w_gany) begin
      w_cur = r_ctx[w_gidx];
      w_nxt = seq_next(w_cur, bus.ch_bit[w_gidx]);
      w_hit = is_hit(w_cur, w_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) r_ctx[c] <= S0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (bus.ch_clear[c])
          r_ctx[c] <= S0;
        else if (w_gany && (w_gidx == CHW'(c)))
          r_ctx[c] <= w_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr <= '0;
    end else if (w_gany) begin
      r_rrPtr <= (w_gidx == CHW'(NCH-1)) ? '0 : w_gidx + CHW'(1);
    end
  end

  // A fresh hit overwrites an event being accepted this cycle, avoiding a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_detValid <= 1'b0;
      r_detCh    <= '0;
    end else if (w_hit) begin
      r_detValid <= 1'b1;
      r_detCh    <= w_gidx;
    end else if (bus.det_ready) begin
      r_detValid <= 1'b0;
    end
  end

endmodule
